pcm_ring_reader: RTL
====================

Name: pcm_ring_reader

Overview:
- Avalon-MM read master that drains 32-bit stereo PCM words from the on-chip program/data RAM ring buffer, downstream of the RAM.
- The MP3 decoder running on the CPU fills the ring and publishes its write pointer. This block prefetches words into a small FIFO and emits one stereo sample per sample-rate strobe to the audio serializer.
- Reports consumption pointer, FIFO level and underruns back to software.

Parameters:
- ADDR_W, 12, RAM word-address width.
- BUF_BASE, 0, first RAM word address of the ring.
- BUF_WORDS, 4096, ring length in words; any value 2..2^ADDR_W-BUF_BASE.
- FIFO_DEPTH, 4, prefetch FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  playback enable from CSR
- wr_ptr  in  ADDR_W  producer ring offset (next word the decoder will write)
- rd_ptr  out  ADDR_W  ring offset of next word to fetch
- ram_address  out  ADDR_W  RAM word address
- ram_chipselect  out  1  read request
- ram_write  out  1  tied 0
- ram_byteenable  out  4  tied 4'hF
- ram_clken  out  1  tied 1
- ram_readdata  in  32  RAM data, valid the cycle after request
- sample_tick  in  1  one-cycle sample-rate strobe
- pcm_left  out  16  left sample
- pcm_right  out  16  right sample
- pcm_valid  out  1  one-cycle pulse with each sample
- underrun  out  1  sticky underrun flag
- underrun_clr  in  1  clears underrun
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values:
  - rd_ptr=0, fifo_level=0, ram_chipselect=0, ram_address=BUF_BASE.
  - pcm_left=0, pcm_right=0, pcm_valid=0, underrun=0.
  - FSM=IDLE, in-flight=0.
- Word format: ram_readdata[31:16]=left, [15:0]=right, two's complement, passed unmodified.
- Read issue:
  - Request in cycle t: ram_chipselect=1, ram_address=BUF_BASE+rd_ptr.
  - Data is captured and pushed into the FIFO in cycle t+1 (fixed latency 1).
  - Issue condition: FSM in PREFILL or PLAY, rd_ptr != wr_ptr, and fifo_level + inflight < FIFO_DEPTH.
  - Back-to-back issue is allowed every cycle.
- rd_ptr increments on each issue; at BUF_WORDS-1 it wraps to 0. Ring empty is rd_ptr == wr_ptr, so the producer must keep one slot free.
- FSM:
  - IDLE: no issue; FIFO held empty; return data discarded. Moves to PREFILL when enable=1.
  - PREFILL: issuing. Ticks produce pcm_valid with 0/0 and do not set underrun. Moves to PLAY when fifo_level == FIFO_DEPTH.
  - PLAY: on each tick pop one word.
  - From any state, enable=0 moves to IDLE next cycle. The FIFO is flushed, a read still in flight is discarded, and rd_ptr holds (prefetched words are dropped).
- Output timing: sample_tick in cycle t gives pcm_left, pcm_right and pcm_valid registered in t+1. pcm_left/pcm_right hold until the next tick.
- Underrun: a tick in PLAY with registered fifo_level==0 outputs 0/0 with pcm_valid=1 and sets underrun.
  - A push arriving in the same cycle does not satisfy that tick.
  - The FSM stays in PLAY.
- Simultaneous push and pop in one cycle: level unchanged, order preserved.
- underrun_clr and an underrun event in the same cycle: underrun ends set.
- Ticks in IDLE produce no pcm_valid.
- Reset mid-transfer: all state returns to reset values next cycle; the outstanding return is ignored.

Optional Feature:
- Macro PCM_UNDERRUN_HOLD_EN.
- Defined: an underrun tick repeats the last emitted left/right pair instead of 0/0; the underrun flag is still set. Ticks in PREFILL still output 0/0.
- Undefined: underrun outputs 0/0.

Test Plan:
- Reset, enable=1, wr_ptr=8, RAM[0..7]=32'h0001_FFFF+i -> four reads at addresses 0..3 on consecutive cycles, PREFILL→PLAY once fifo_level=4, rd_ptr=4 then continues to 8 and stops.
- In PLAY, tick every 10 cycles -> pcm_left=16'h0001+carry, pcm_right in order, pcm_valid exactly one cycle after each tick, no underrun.
- wr_ptr held equal to rd_ptr, ticks continue until FIFO drains -> 5th tick gives 0/0 with underrun=1 (last pair with PCM_UNDERRUN_HOLD_EN); underrun_clr clears it.
- BUF_BASE=16, BUF_WORDS=8, wr_ptr cycles through 0..7 -> ram_address sequence 16..23,16..; rd_ptr wraps 7→0.
- enable dropped in the cycle a read is issued -> returned word not pushed, fifo_level=0 next cycle, rd_ptr holds, no pcm_valid while IDLE.
- Tick and push coincide with fifo_level=2 -> fifo_level stays 2, output equals oldest word.

Source files
------------

// File: rtl/pcm_ring_reader.sv
// Prefetching Avalon-MM read master: drains stereo PCM words from a RAM ring
// into a small FIFO and emits one sample per sample_tick. Option: PCM_UNDERRUN_HOLD_EN.
module pcm_ring_reader #(
   parameter int unsigned ADDR_W     = 12,
   parameter int unsigned BUF_BASE   = 0,
   parameter int unsigned BUF_WORDS  = 4096,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [ADDR_W-1:0]           wr_ptr,
   output logic [ADDR_W-1:0]           rd_ptr,
   output logic [ADDR_W-1:0]           ram_address,
   output logic                        ram_chipselect,
   output logic                        ram_write,
   output logic [3:0]                  ram_byteenable,
   output logic                        ram_clken,
   input  logic [31:0]                 ram_readdata,
   input  logic                        sample_tick,
   output logic [15:0]                 pcm_left,
   output logic [15:0]                 pcm_right,
   output logic                        pcm_valid,
   output logic                        underrun,
   input  logic                        underrun_clr,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PREFILL = 2'd1,
      ST_PLAY    = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [ADDR_W-1:0]  r_rd_ptr;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_cs;
   logic               r_rv;
   logic [LVL_W-1:0]   r_level;
   logic [PTR_W-1:0]   r_wr_idx;
   logic [PTR_W-1:0]   r_rd_idx;
   logic [31:0]        r_mem [FIFO_DEPTH];
   logic [15:0]        r_left;
   logic [15:0]        r_right;
   logic               r_valid;
   logic               r_underrun;

   logic               w_issue;
   logic               w_push;
   logic               w_pop;
   logic               w_flush;
   logic               w_emit;
   logic               w_load_head;
   logic               w_load_zero;
   logic               w_underrun_ev;
   logic               w_can_issue;
   logic               w_full;
   logic               w_empty;
   int unsigned        w_occ;
   logic [ADDR_W-1:0]  w_rd_nxt;
   logic [31:0]        w_head;

   // Words committed to the FIFO: stored, returning this cycle, requested this cycle.
   assign w_occ       = 32'(r_level) + 32'(r_cs) + 32'(r_rv);
   assign w_can_issue = (r_rd_ptr != wr_ptr) && (w_occ < FIFO_DEPTH);
   assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
   assign w_empty     = (r_level == '0);
   assign w_rd_nxt    = (r_rd_ptr == ADDR_W'(BUF_WORDS - 1)) ? '0 : r_rd_ptr + ADDR_W'(1);
   assign w_head      = r_mem[r_rd_idx];

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_issue       = 1'b0;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      w_flush       = 1'b0;
      w_emit        = 1'b0;
      w_load_head   = 1'b0;
      w_load_zero   = 1'b0;
      w_underrun_ev = 1'b0;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
         w_flush     = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_PREFILL;
               w_flush     = 1'b1;
            end
            ST_PREFILL: begin
               w_issue = w_can_issue;
               w_push  = r_rv;
               if (sample_tick) begin
                  w_emit      = 1'b1;
                  w_load_zero = 1'b1;
               end
               if (w_full) w_state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
               w_issue = w_can_issue;
               w_push  = r_rv;
               if (sample_tick) begin
                  w_emit = 1'b1;
                  // A word landing this same cycle is not yet visible to the tick.
                  if (w_empty) begin
                     w_underrun_ev = 1'b1;
`ifdef PCM_UNDERRUN_HOLD_EN
                     w_load_zero   = 1'b0;
`else
                     w_load_zero   = 1'b1;
`endif
                  end else begin
                     w_pop       = 1'b1;
                     w_load_head = 1'b1;
                  end
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_idx] <= ram_readdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr   <= '0;
         r_addr     <= ADDR_W'(BUF_BASE);
         r_cs       <= 1'b0;
         r_rv       <= 1'b0;
         r_level    <= '0;
         r_wr_idx   <= '0;
         r_rd_idx   <= '0;
         r_left     <= '0;
         r_right    <= '0;
         r_valid    <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_cs <= w_issue;
         r_rv <= r_cs;
         if (w_issue) begin
            r_addr   <= ADDR_W'(BUF_BASE) + r_rd_ptr;
            r_rd_ptr <= w_rd_nxt;
         end

         if (w_flush) begin
            r_level  <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
         end else begin
            if (w_push) r_wr_idx <= r_wr_idx + PTR_W'(1);
            if (w_pop)  r_rd_idx <= r_rd_idx + PTR_W'(1);
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + LVL_W'(1);
               2'b01:   r_level <= r_level - LVL_W'(1);
               default: r_level <= r_level;
            endcase
         end

         r_valid <= w_emit;
         if (w_load_head) begin
            r_left  <= w_head[31:16];
            r_right <= w_head[15:0];
         end else if (w_load_zero) begin
            r_left  <= '0;
            r_right <= '0;
         end

         // An underrun in the same cycle as a clear wins.
         if (w_underrun_ev)     r_underrun <= 1'b1;
         else if (underrun_clr) r_underrun <= 1'b0;
      end
   end

   assign rd_ptr         = r_rd_ptr;
   assign ram_address    = r_addr;
   assign ram_chipselect = r_cs;
   assign ram_write      = 1'b0;
   assign ram_byteenable = 4'hF;
   assign ram_clken      = 1'b1;
   assign pcm_left       = r_left;
   assign pcm_right      = r_right;
   assign pcm_valid      = r_valid;
   assign underrun       = r_underrun;
   assign fifo_level     = r_level;

endmodule
